// File: rtl/pdm_tx_pkg.sv
// rtl/pdm_tx_pkg.sv - shared sonar constants and types for the PDM transmitter
package pdm_tx_pkg;

    localparam int BUS_WIDTH  = 16;
    localparam int INT_W      = 20;
    localparam int FIFO_DEPTH = 4;

    // Full-scale feedback levels fed back into both integrators
    localparam logic signed [15:0] FB_POS = 16'sh7FFF;
    localparam logic signed [15:0] FB_NEG = 16'sh8000;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/pdm_tx_fifo.sv
// rtl/pdm_tx_fifo.sv - synchronous sample FIFO with push/pop/flush
module pdm_tx_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             flush_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign data_o  = mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        do_push  = push_i && !full_o;
        do_pop   = pop_i && !empty_o;
        // A flush empties the queue but still accepts a same-cycle push
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
            if (do_push) begin
                mem_d[0] = data_i;
                wr_ptr_d = AW'(1);
                count_d  = (AW+1)'(1);
            end
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = data_i;
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            count_d = count_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/pdm_tx.sv
// rtl/pdm_tx.sv - PCM to PDM transmitter with second-order sigma-delta modulator
module pdm_tx
    import pdm_tx_pkg::*;
#(
    parameter int BUS_WIDTH  = pdm_tx_pkg::BUS_WIDTH,
    parameter int FIFO_DEPTH = pdm_tx_pkg::FIFO_DEPTH,
    parameter int INT_W      = pdm_tx_pkg::INT_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en_i,
    input  logic [7:0]           clk_div_i,
    input  logic [7:0]           osr_i,
    input  logic [BUS_WIDTH-1:0] pcm_i,
    input  logic                 pcm_valid_i,
    output logic                 pcm_ready_o,
    output logic                 pdm_clk_o,
    output logic                 pdm_o,
    output logic                 busy_o,
    output logic                 underrun_o,
    input  logic                 clr_underrun_i
);

    localparam int SW = INT_W + 2;

    state_e                      state_q, state_d;
    logic [7:0]                  div_q, div_d, osr_q, osr_d;
    logic [7:0]                  cnt_q, cnt_d, bit_cnt_q, bit_cnt_d;
    logic signed [BUS_WIDTH-1:0] x_q, x_d;
    logic signed [INT_W-1:0]     i1_q, i1_d, i2_q, i2_d, i1_new, i2_new;
    logic                        pdm_clk_q, pdm_clk_d, pdm_q, pdm_d;
    logic                        underrun_q, underrun_d, ur_set;
    logic                        fifo_pop, fifo_flush, fifo_full, fifo_empty;
    logic [BUS_WIDTH-1:0]        fifo_dout;
    logic signed [SW-1:0]        fb_w, sum1, sum2;

    function automatic logic signed [INT_W-1:0] sat(input logic signed [SW-1:0] v);
        logic signed [SW-1:0] hi, lo;
        hi = $signed({3'b000, {(INT_W-1){1'b1}}});
        lo = $signed({3'b111, {(INT_W-1){1'b0}}});
        if (v > hi)      return hi[INT_W-1:0];
        else if (v < lo) return lo[INT_W-1:0];
        else             return v[INT_W-1:0];
    endfunction

    pdm_tx_fifo #(.WIDTH(BUS_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (pcm_valid_i && pcm_ready_o),
        .pop_i   (fifo_pop),
        .flush_i (fifo_flush),
        .data_i  (pcm_i),
        .data_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign pcm_ready_o = !fifo_full;
    assign pdm_clk_o   = pdm_clk_q;
    assign pdm_o       = pdm_q;
    assign busy_o      = (state_q == RUN);
    assign underrun_o  = underrun_q;

    // Wide sums hold the worst case before clamping, so nothing wraps
    always_comb begin
        fb_w   = pdm_q ? SW'(FB_POS) : SW'(FB_NEG);
        sum1   = SW'(i1_q) + SW'(x_q) - fb_w;
        i1_new = sat(sum1);
        sum2   = SW'(i2_q) + SW'(i1_new) - fb_w;
        i2_new = sat(sum2);
    end

    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        osr_d      = osr_q;
        cnt_d      = cnt_q;
        bit_cnt_d  = bit_cnt_q;
        x_d        = x_q;
        i1_d       = i1_q;
        i2_d       = i2_q;
        pdm_clk_d  = pdm_clk_q;
        pdm_d      = pdm_q;
        fifo_pop   = 1'b0;
        fifo_flush = 1'b0;
        ur_set     = 1'b0;
        case (state_q)
            IDLE: begin
                if (en_i && !fifo_empty) begin
                    state_d   = RUN;
                    div_d     = clk_div_i;
                    osr_d     = (osr_i == 8'd0) ? 8'd1 : osr_i;
                    fifo_pop  = 1'b1;
                    x_d       = $signed(fifo_dout);
                    cnt_d     = '0;
                    bit_cnt_d = '0;
                    pdm_clk_d = 1'b0;
                end
            end
            RUN: begin
                if (!en_i) begin
                    state_d    = IDLE;
                    pdm_clk_d  = 1'b0;
                    pdm_d      = 1'b0;
                    i1_d       = '0;
                    i2_d       = '0;
                    fifo_flush = 1'b1;
                end else if (cnt_q == div_q) begin
                    cnt_d     = '0;
                    pdm_clk_d = ~pdm_clk_q;
                    // Falling edge of the bit clock is the modulator strobe
                    if (pdm_clk_q) begin
                        i1_d  = i1_new;
                        i2_d  = i2_new;
                        pdm_d = ~i2_new[INT_W-1];
                        if (bit_cnt_q == osr_q - 8'd1) begin
                            bit_cnt_d = '0;
                            if (!fifo_empty) begin
                                fifo_pop = 1'b1;
                                x_d      = $signed(fifo_dout);
                            end else begin
                                x_d    = '0;
                                ur_set = 1'b1;
                            end
                        end else begin
                            bit_cnt_d = bit_cnt_q + 8'd1;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
        underrun_d = ur_set | (underrun_q & ~clr_underrun_i);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            div_q      <= '0;
            osr_q      <= 8'd1;
            cnt_q      <= '0;
            bit_cnt_q  <= '0;
            x_q        <= '0;
            i1_q       <= '0;
            i2_q       <= '0;
            pdm_clk_q  <= 1'b0;
            pdm_q      <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            osr_q      <= osr_d;
            cnt_q      <= cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            x_q        <= x_d;
            i1_q       <= i1_d;
            i2_q       <= i2_d;
            pdm_clk_q  <= pdm_clk_d;
            pdm_q      <= pdm_d;
            underrun_q <= underrun_d;
        end
    end

endmodule
